// File: rtl/id_stage.sv
// Decode stage of the 5-stage ARM-subset pipeline: field decode, condition check,
// RAW hazard detection against EXE/MEM, and the ID/EX pipeline register.
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_if,
  input  logic [31:0] pc_if,
  input  logic [3:0]  status,
  input  logic [31:0] reg_out_1,
  input  logic [31:0] reg_out_2,
  input  logic [3:0]  exe_dest,
  input  logic [3:0]  mem_dest,
  input  logic        exe_wb_en,
  input  logic        mem_wb_en,
  input  logic        flush,
  output logic [3:0]  src_1,
  output logic [3:0]  src_2,
  output logic        hazard,
  output logic [31:0] id_pc,
  output logic [31:0] id_val_rn,
  output logic [31:0] id_val_rm,
  output logic [3:0]  id_dest,
  output logic [3:0]  id_src1,
  output logic [3:0]  id_src2,
  output logic [3:0]  id_exe_cmd,
  output logic        id_wb_en,
  output logic        id_mem_r,
  output logic        id_mem_w,
  output logic        id_b,
  output logic        id_s,
  output logic        id_imm,
  output logic        id_valid,
  output logic [11:0] id_shift_op,
  output logic [23:0] id_imm24
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] valRn;
    logic [31:0] valRm;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  exeCmd;
    logic        wbEn;
    logic        memR;
    logic        memW;
    logic        b;
    logic        s;
    logic        imm;
    logic        valid;
    logic [11:0] shiftOp;
    logic [23:0] imm24;
  } idex_t;

  logic [3:0] w_cond;
  logic [1:0] w_mode;
  logic       w_i;
  logic [3:0] w_opcode;
  logic       w_s;
  logic [3:0] w_rn;
  logic [3:0] w_rd;
  logic [3:0] w_rm;
  logic       w_isStr;
  logic       w_usesRn;
  logic       w_usesSrc2;
  logic       w_hazRn;
  logic       w_hazSrc2;
  logic       w_condTrue;
  logic       w_go;
  logic       w_known;
  logic [3:0] w_cmd;
  logic       w_wbEn;
  logic       w_memR;
  logic       w_memW;
  logic       w_b;
  logic       w_sOut;
  logic       w_imm;
  idex_t      w_next;
  idex_t      r_idex;

  assign w_cond   = instr_if[31:28];
  assign w_mode   = instr_if[27:26];
  assign w_i      = instr_if[25];
  assign w_opcode = instr_if[24:21];
  assign w_s      = instr_if[20];
  assign w_rn     = instr_if[19:16];
  assign w_rd     = instr_if[15:12];
  assign w_rm     = instr_if[3:0];

  assign w_isStr = (w_mode == 2'b01) && !w_s;
  assign src_1   = w_rn;
  assign src_2   = w_isStr ? w_rd : w_rm;

  // No WB-stage compare: the register file writes on negedge, ahead of our capture.
  assign w_usesRn   = ((w_mode == 2'b00) && (w_opcode != 4'b1101) && (w_opcode != 4'b1111))
                      || (w_mode == 2'b01);
  assign w_usesSrc2 = ((w_mode == 2'b00) && !w_i) || w_isStr;
  assign w_hazRn    = (exe_wb_en && (w_rn == exe_dest)) || (mem_wb_en && (w_rn == mem_dest));
  assign w_hazSrc2  = (exe_wb_en && (src_2 == exe_dest)) || (mem_wb_en && (src_2 == mem_dest));
  assign hazard     = (w_usesRn && w_hazRn) || (w_usesSrc2 && w_hazSrc2);

  always_comb begin
    w_condTrue = 1'b0;
    case (w_cond)
      4'b0000: w_condTrue = status[2];
      4'b0001: w_condTrue = !status[2];
      4'b0010: w_condTrue = status[1];
      4'b0011: w_condTrue = !status[1];
      4'b0100: w_condTrue = status[3];
      4'b0101: w_condTrue = !status[3];
      4'b0110: w_condTrue = status[0];
      4'b0111: w_condTrue = !status[0];
      4'b1000: w_condTrue = status[1] && !status[2];
      4'b1001: w_condTrue = !status[1] || status[2];
      4'b1010: w_condTrue = (status[3] == status[0]);
      4'b1011: w_condTrue = (status[3] != status[0]);
      4'b1100: w_condTrue = !status[2] && (status[3] == status[0]);
      4'b1101: w_condTrue = status[2] || (status[3] != status[0]);
      4'b1110: w_condTrue = 1'b1;
      default: w_condTrue = 1'b0;
    endcase
  end

  always_comb begin
    w_known = 1'b1;
    w_cmd   = 4'b0000;
    w_wbEn  = 1'b0;
    w_memR  = 1'b0;
    w_memW  = 1'b0;
    w_b     = 1'b0;
    w_sOut  = 1'b0;
    w_imm   = 1'b0;
    case (w_mode)
      2'b00: begin
        case (w_opcode)
          4'b1101: begin w_cmd = 4'b0001; w_wbEn = 1'b1; end
          4'b1111: begin w_cmd = 4'b1001; w_wbEn = 1'b1; end
          4'b0100: begin w_cmd = 4'b0010; w_wbEn = 1'b1; end
          4'b0101: begin w_cmd = 4'b0011; w_wbEn = 1'b1; end
          4'b0010: begin w_cmd = 4'b0100; w_wbEn = 1'b1; end
          4'b0110: begin w_cmd = 4'b0101; w_wbEn = 1'b1; end
          4'b0000: begin w_cmd = 4'b0110; w_wbEn = 1'b1; end
          4'b1100: begin w_cmd = 4'b0111; w_wbEn = 1'b1; end
          4'b0001: begin w_cmd = 4'b1000; w_wbEn = 1'b1; end
          4'b1010: w_cmd = 4'b0100;
          4'b1000: w_cmd = 4'b0110;
          default: w_known = 1'b0;
        endcase
        w_sOut = w_known && w_s;
        w_imm  = w_known && w_i;
      end
      2'b01: begin
        w_cmd  = 4'b0010;
        w_sOut = w_s;
        w_imm  = w_i;
        w_memR = w_s;
        w_wbEn = w_s;
        w_memW = !w_s;
      end
      2'b10: begin
        w_b   = 1'b1;
        w_imm = w_i;
      end
      default: w_known = 1'b0;
    endcase
  end

  // A false condition keeps the data fields but strips every side-effecting control bit.
  assign w_go = w_condTrue && !hazard;

  always_comb begin
    w_next         = '0;
    w_next.pc      = pc_if;
    w_next.valRn   = reg_out_1;
    w_next.valRm   = reg_out_2;
    w_next.dest    = w_rd;
    w_next.src1    = src_1;
    w_next.src2    = src_2;
    w_next.exeCmd  = w_cmd;
    w_next.wbEn    = w_wbEn && w_go;
    w_next.memR    = w_memR && w_go;
    w_next.memW    = w_memW && w_go;
    w_next.b       = w_b && w_go;
    w_next.s       = w_sOut && w_go;
    w_next.imm     = w_imm;
    w_next.valid   = w_go;
    w_next.shiftOp = instr_if[11:0];
    w_next.imm24   = instr_if[23:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idex <= '0;
    end else if (flush || hazard) begin
      r_idex <= '0;
    end else begin
      r_idex <= w_next;
    end
  end

  assign id_pc       = r_idex.pc;
  assign id_val_rn   = r_idex.valRn;
  assign id_val_rm   = r_idex.valRm;
  assign id_dest     = r_idex.dest;
  assign id_src1     = r_idex.src1;
  assign id_src2     = r_idex.src2;
  assign id_exe_cmd  = r_idex.exeCmd;
  assign id_wb_en    = r_idex.wbEn;
  assign id_mem_r    = r_idex.memR;
  assign id_mem_w    = r_idex.memW;
  assign id_b        = r_idex.b;
  assign id_s        = r_idex.s;
  assign id_imm      = r_idex.imm;
  assign id_valid    = r_idex.valid;
  assign id_shift_op = r_idex.shiftOp;
  assign id_imm24    = r_idex.imm24;

endmodule

// File: tb/tb_id_stage.sv
// Table-driven bench for id_stage: a queue scoreboard holds the expected ID/EX contents
// for each driven instruction and is checked one posedge later.
module tb_id_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] valRn;
    logic [31:0] valRm;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  exeCmd;
    logic        wbEn;
    logic        memR;
    logic        memW;
    logic        b;
    logic        s;
    logic        imm;
    logic        valid;
    logic [11:0] shiftOp;
    logic [23:0] imm24;
  } out_t;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  status;
    logic [3:0]  exeDest;
    logic        exeWb;
    logic [3:0]  memDest;
    logic        memWb;
    logic        flush;
    logic        expHazard;
    logic [3:0]  expSrc2;
    logic [3:0]  expCmd;
    logic        expWb;
    logic        expMemR;
    logic        expMemW;
    logic        expB;
    logic        expS;
    logic        expImm;
    logic        expValid;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [31:0] instr_if;
  logic [31:0] pc_if;
  logic [3:0]  status;
  logic [31:0] reg_out_1;
  logic [31:0] reg_out_2;
  logic [3:0]  exe_dest;
  logic [3:0]  mem_dest;
  logic        exe_wb_en;
  logic        mem_wb_en;
  logic        flush;
  logic [3:0]  src_1;
  logic [3:0]  src_2;
  logic        hazard;
  logic [31:0] id_pc;
  logic [31:0] id_val_rn;
  logic [31:0] id_val_rm;
  logic [3:0]  id_dest;
  logic [3:0]  id_src1;
  logic [3:0]  id_src2;
  logic [3:0]  id_exe_cmd;
  logic        id_wb_en;
  logic        id_mem_r;
  logic        id_mem_w;
  logic        id_b;
  logic        id_s;
  logic        id_imm;
  logic        id_valid;
  logic [11:0] id_shift_op;
  logic [23:0] id_imm24;

  int   numCompared = 0;
  int   numMismatched = 0;
  out_t expQ[$];
  vec_t vecs[$];

  id_stage dut (
    .clk(clk), .rst(rst), .instr_if(instr_if), .pc_if(pc_if), .status(status),
    .reg_out_1(reg_out_1), .reg_out_2(reg_out_2), .exe_dest(exe_dest), .mem_dest(mem_dest),
    .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en), .flush(flush),
    .src_1(src_1), .src_2(src_2), .hazard(hazard),
    .id_pc(id_pc), .id_val_rn(id_val_rn), .id_val_rm(id_val_rm),
    .id_dest(id_dest), .id_src1(id_src1), .id_src2(id_src2), .id_exe_cmd(id_exe_cmd),
    .id_wb_en(id_wb_en), .id_mem_r(id_mem_r), .id_mem_w(id_mem_w), .id_b(id_b),
    .id_s(id_s), .id_imm(id_imm), .id_valid(id_valid),
    .id_shift_op(id_shift_op), .id_imm24(id_imm24)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t actualOut();
    out_t a;
    a.pc = id_pc;         a.valRn = id_val_rn;   a.valRm = id_val_rm;
    a.dest = id_dest;     a.src1 = id_src1;      a.src2 = id_src2;
    a.exeCmd = id_exe_cmd;
    a.wbEn = id_wb_en;    a.memR = id_mem_r;     a.memW = id_mem_w;
    a.b = id_b;           a.s = id_s;            a.imm = id_imm;   a.valid = id_valid;
    a.shiftOp = id_shift_op;
    a.imm24 = id_imm24;
    return a;
  endfunction

  function automatic vec_t mk(input logic [31:0] instr, input logic [3:0] st,
                              input logic [3:0] eD, input logic eW,
                              input logic [3:0] mD, input logic mW, input logic fl,
                              input logic hz, input logic [3:0] s2, input logic [3:0] cmd,
                              input logic [6:0] ctl);
    vec_t v;
    v.instr = instr;  v.status = st;
    v.exeDest = eD;   v.exeWb = eW;  v.memDest = mD;  v.memWb = mW;  v.flush = fl;
    v.expHazard = hz; v.expSrc2 = s2; v.expCmd = cmd;
    {v.expWb, v.expMemR, v.expMemW, v.expB, v.expS, v.expImm, v.expValid} = ctl;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    numCompared++;
    if (act !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pops one expected ID/EX image per posedge, shortly after the register updates.
  always @(posedge clk) begin
    #1;
    if (expQ.size() > 0) checkOutput("idex", actualOut(), expQ.pop_front());
  end

  task automatic applyStimulus(input vec_t v, input int idx);
    out_t e;
    @(negedge clk);
    instr_if  = v.instr;
    pc_if     = 32'h0000_1000 + 32'(idx * 4);
    status    = v.status;
    reg_out_1 = 32'(idx * 3 + 5);
    reg_out_2 = 32'(idx * 3 + 7);
    exe_dest  = v.exeDest;
    exe_wb_en = v.exeWb;
    mem_dest  = v.memDest;
    mem_wb_en = v.memWb;
    flush     = v.flush;
    #1;
    checkOutput("hazard", {159'd0, hazard}, {159'd0, v.expHazard});
    checkOutput("src_2", {156'd0, src_2}, {156'd0, v.expSrc2});
    checkOutput("src_1", {156'd0, src_1}, {156'd0, v.instr[19:16]});
    e = '0;
    if (!v.flush && !v.expHazard) begin
      e.pc = pc_if;  e.valRn = reg_out_1;  e.valRm = reg_out_2;
      e.dest = v.instr[15:12];  e.src1 = v.instr[19:16];  e.src2 = v.expSrc2;
      e.exeCmd = v.expCmd;
      {e.wbEn, e.memR, e.memW, e.b, e.s, e.imm, e.valid} =
        {v.expWb, v.expMemR, v.expMemW, v.expB, v.expS, v.expImm, v.expValid};
      e.shiftOp = v.instr[11:0];
      e.imm24 = v.instr[23:0];
    end
    expQ.push_back(e);
  endtask

  task automatic drainQueue();
    int budget = 5;
    while (expQ.size() > 0 && budget > 0) begin
      @(posedge clk);
      #2;
      budget--;
    end
    if (expQ.size() > 0) begin
      checkOutput("drain", 160'(expQ.size()), 160'd0);
      expQ.delete();
    end
  endtask

  initial begin
    // ctl = {wb, memR, memW, b, s, imm, valid}
    vecs.push_back(mk(32'hE0821003, 4'b0000, 4'd0, 0, 4'd0, 0, 0, 0, 4'd3, 4'b0010, 7'b1000001));
    vecs.push_back(mk(32'hE0821003, 4'b0000, 4'd2, 1, 4'd0, 0, 0, 1, 4'd3, 4'b0000, 7'b0000000));
    vecs.push_back(mk(32'hE0821003, 4'b0000, 4'd2, 0, 4'd0, 0, 0, 0, 4'd3, 4'b0010, 7'b1000001));
    vecs.push_back(mk(32'hE3A0000A, 4'b0000, 4'd0, 1, 4'd0, 0, 0, 0, 4'hA, 4'b0001, 7'b1000011));
    vecs.push_back(mk(32'h00821003, 4'b0000, 4'd0, 0, 4'd0, 0, 0, 0, 4'd3, 4'b0010, 7'b0000000));
    vecs.push_back(mk(32'h00821003, 4'b0100, 4'd0, 0, 4'd0, 0, 0, 0, 4'd3, 4'b0010, 7'b1000001));
    vecs.push_back(mk(32'hE5821000, 4'b0000, 4'd0, 0, 4'd0, 0, 0, 0, 4'd1, 4'b0010, 7'b0010001));
    vecs.push_back(mk(32'hE5921000, 4'b0000, 4'd0, 0, 4'd0, 0, 0, 0, 4'd0, 4'b0010, 7'b1100101));
    vecs.push_back(mk(32'hEA000004, 4'b0000, 4'd0, 0, 4'd0, 0, 0, 0, 4'd4, 4'b0000, 7'b0001011));
    vecs.push_back(mk(32'hE0821003, 4'b0000, 4'd0, 0, 4'd0, 0, 1, 0, 4'd3, 4'b0010, 7'b1000001));
    vecs.push_back(mk(32'hE0821003, 4'b0000, 4'd2, 1, 4'd0, 0, 1, 1, 4'd3, 4'b0000, 7'b0000000));
    vecs.push_back(mk(32'hE0554006, 4'b0000, 4'd0, 0, 4'd6, 1, 0, 1, 4'd6, 4'b0000, 7'b0000000));
    vecs.push_back(mk(32'hE0554006, 4'b0000, 4'd0, 0, 4'd6, 0, 0, 0, 4'd6, 4'b0100, 7'b1000101));
    vecs.push_back(mk(32'hE1510002, 4'b0000, 4'd0, 0, 4'd1, 0, 0, 0, 4'd2, 4'b0100, 7'b0000101));
    vecs.push_back(mk(32'hC0821003, 4'b1001, 4'd0, 0, 4'd0, 0, 0, 0, 4'd3, 4'b0010, 7'b1000001));
    vecs.push_back(mk(32'hB0821003, 4'b1000, 4'd0, 0, 4'd0, 0, 0, 0, 4'd3, 4'b0010, 7'b1000001));
    vecs.push_back(mk(32'hB0821003, 4'b1001, 4'd0, 0, 4'd0, 0, 0, 0, 4'd3, 4'b0010, 7'b0000000));
    vecs.push_back(mk(32'h80821003, 4'b0010, 4'd0, 0, 4'd0, 0, 0, 0, 4'd3, 4'b0010, 7'b1000001));
    vecs.push_back(mk(32'h80821003, 4'b0110, 4'd0, 0, 4'd0, 0, 0, 0, 4'd3, 4'b0010, 7'b0000000));
    vecs.push_back(mk(32'hF0821003, 4'b1111, 4'd0, 0, 4'd0, 0, 0, 0, 4'd3, 4'b0010, 7'b0000000));
    vecs.push_back(mk(32'hE0621003, 4'b0000, 4'd0, 0, 4'd0, 0, 0, 0, 4'd3, 4'b0000, 7'b0000001));
    vecs.push_back(mk(32'hE1A00003, 4'b0000, 4'd3, 1, 4'd0, 0, 0, 1, 4'd3, 4'b0000, 7'b0000000));
    vecs.push_back(mk(32'hE5821000, 4'b0000, 4'd0, 0, 4'd1, 1, 0, 1, 4'd1, 4'b0000, 7'b0000000));
    vecs.push_back(mk(32'hE5921000, 4'b0000, 4'd0, 0, 4'd1, 1, 0, 0, 4'd0, 4'b0010, 7'b1100101));

    rst = 1'b0;
    instr_if = 32'hE0821003;  pc_if = 32'h40;  status = 4'b0000;
    reg_out_1 = 32'd5;  reg_out_2 = 32'd7;
    exe_dest = 4'd2;  exe_wb_en = 1'b1;  mem_dest = 4'd0;  mem_wb_en = 1'b0;  flush = 1'b0;
    #2;
    checkOutput("reset_state", actualOut(), '0);
    checkOutput("reset_hazard", {159'd0, hazard}, {159'd0, 1'b1});
    @(posedge clk);
    #1;
    checkOutput("reset_hold", actualOut(), '0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);
    drainQueue();

    // Async reset mid-cycle after a valid load, then recovery on the next edge.
    applyStimulus(vecs[0], 0);
    drainQueue();
    #1;
    rst = 1'b0;
    #1;
    checkOutput("async_reset", actualOut(), '0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(vecs[3], 3);
    drainQueue();

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 5-stage ARM-subset pipeline. It sits between the IF/ID register and the execute stage. Each cycle it:
- decodes the fetched instruction;
- drives the register-file read addresses and receives the operand values;
- evaluates the condition field against NZCV;
- detects RAW hazards against the EXE and MEM stages;
- registers everything into the ID/EX pipeline register, with flush and bubble-insertion support.

## Interface
- No parameters; all widths are fixed by the ISA (32-bit data, 16 registers).
- clk  in  1  pipeline clock, posedge.
- rst  in  1  reset rst, asynchronous, active-low.
- instr_if  in  32  instruction from IF/ID.
- pc_if  in  32  PC+4 from IF/ID.
- status  in  4  NZCV from status register, {N,Z,C,V} = [3:0].
- reg_out_1, reg_out_2  in  32  register-file read data for src_1/src_2.
- exe_dest, mem_dest  in  4  destination register in EXE / MEM.
- exe_wb_en, mem_wb_en  in  1  writeback enable in EXE / MEM.
- flush  in  1  branch taken in EXE; kill the instruction being decoded.
- src_1, src_2  out  4  register-file read addresses (combinational).
- hazard  out  1  stall request to PC and IF/ID (combinational).
- id_pc, id_val_rn, id_val_rm  out  32  registered PC, Rn value, second-operand value.
- id_dest, id_src1, id_src2  out  4  registered Rd, src_1, src_2 (consumed by the forwarding unit).
- id_exe_cmd  out  4  ALU command.
- id_wb_en, id_mem_r, id_mem_w, id_b, id_s, id_imm, id_valid  out  1  registered control bits.
- id_shift_op  out  12  instr[11:0].
- id_imm24  out  24  instr[23:0].

## Operation
Field decode:
- cond=[31:28], mode=[27:26], I=[25], opcode=[24:21], S=[20], Rn=[19:16], Rd=[15:12], Rm=[3:0].

Register-file addresses:
- src_1 = Rn.
- src_2 = Rd for STR (mode 01, S=0); otherwise Rm.

Opcode → exe_cmd for mode 00:
- MOV 1101→0001, MVN 1111→1001, ADD 0100→0010, ADC 0101→0011, SUB 0010→0100, SBC 0110→0101.
- AND 0000→0110, ORR 1100→0111, EOR 0001→1000, CMP 1010→0100, TST 1000→0110.
- wb_en=1 for all of these except CMP and TST.
- Any other opcode: all control bits 0.

Memory and branch (S passes through as id_s except where noted):
- mode 01, S=1 (LDR): exe_cmd 0010, mem_r=1, wb_en=1.
- mode 01, S=0 (STR): exe_cmd 0010, mem_w=1, wb_en=0.
- mode 10: b=1, wb_en=0, id_s=0.
- mode 11: all control bits 0.

Condition codes:
- EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
- HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
- AL (1110) true; 1111 false.

Hazard detection:
- uses_rn = mode 00 and opcode not MOV/MVN, or mode 01.
- uses_src2 = (mode 00 and I=0), or STR.
- hazard = [uses_rn & ((exe_wb_en & Rn==exe_dest) | (mem_wb_en & Rn==mem_dest))] | [uses_src2 & same test on src_2].
- There is no WB-stage check: the register file writes on negedge, so WB data is visible before this stage's posedge capture.

Control gating:
- wb_en, mem_r, mem_w, b, s are forced to 0 when the condition is false or hazard=1.
- valid_next = cond_true & !hazard.

ID/EX register, on posedge clk, priority rst > flush > hazard > load:
- rst low (async): every id_* output clears to 0.
- flush=1: every id_* output clears to 0, regardless of hazard.
- hazard=1: bubble. All control bits and id_valid load 0; data fields load 0.
- otherwise: all fields load the decoded values.

## Timing
- src_1, src_2, hazard: combinational from instr_if, exe_*, mem_* in the same cycle.
- Decode-to-ID/EX latency is 1 cycle. A stalled instruction is re-presented by the held IF/ID register and loads on the first cycle after hazard drops.
- Reset value of every registered output: 0. hazard follows its inputs during reset.
- flush and hazard in the same cycle: flush wins, result is a bubble. hazard stays asserted combinationally, which is harmless.
- Reset deassertion mid-stream: the first posedge after deassertion loads normally.

## Test plan
- ADD R1,R2,R3 (0xE0821003), R2=5, R3=7, no hazards → next edge: id_val_rn=5, id_val_rm=7, id_exe_cmd=0010, id_dest=1, id_wb_en=1, id_valid=1.
- Same instruction with exe_dest=2, exe_wb_en=1 → hazard=1 that cycle; next edge id_wb_en=0, id_valid=0. Drop exe_wb_en → instruction loads on the following edge.
- MOV R0,#10 (0xE3A0000A) with exe_dest=0, exe_wb_en=1 → hazard=0, id_exe_cmd=0001, id_imm=1, id_shift_op=0x00A.
- ADDEQ (0x00821003) with status=0000 → id_wb_en=0, id_valid=0. Repeat with Z=1 (status=0100) → id_wb_en=1.
- STR R1,[R2] (0xE5821000) → src_2=1, id_mem_w=1, id_wb_en=0. LDR (0xE5921000) → id_mem_r=1, id_wb_en=1. B (0xEA000004) → id_b=1, id_imm24=0x000004.
- flush=1 together with a valid ADD → all id_* outputs 0. Assert rst low mid-cycle → outputs clear immediately, without waiting for a clock edge.
